// File: rtl/bb_stimulus_checker.sv
// bb_stimulus_checker
// Drives a pseudo-random vector sequence into a single-output black-box DUT
// and checks the response against a reference model selected by MODE
// (0 inverter, 1 passthrough, 2 one-cycle register, 3 constant VALUE).
// Optional feature macro: BB_CHECKER_STOP_ON_ERROR_EN ends the run on the
// first mismatch.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_DRIVE | presenting vector i = 0..NUM_VECTORS-1, one per cycle
// S_DRAIN | MODE 2 only: dut_in held, final check of the last vector
// S_DONE  | result held (done, pass, err_count); start reruns
module bb_stimulus_checker #(
  parameter int          MODE        = 0,
  parameter int          WIDTH       = 1,
  parameter int          VALUE       = 1,
  parameter int          NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic [WIDTH-1:0] dut_in,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count
);

  // A zero seed would lock the LFSR, so it falls back to the default seed.
  localparam logic [15:0]      SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [31:0]      VALUE_V  = 32'(VALUE);
  localparam logic [WIDTH-1:0] CONST_W  = VALUE_V[WIDTH-1:0];
  localparam logic [7:0]       LAST     = 8'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      lfsr_nxt;
  logic [7:0]       vcnt;
  logic [WIDTH-1:0] prev_in;
  logic [WIDTH-1:0] expected;
  logic             checked;
  logic             mismatch;
  logic             stop_now;
  logic [7:0]       err_next;

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Reference model and which cycles carry a check; MODE 2 skips the first
  // DRIVE cycle because the register DUT has no valid output yet.
  always_comb begin
    expected = dut_in;
    checked  = 1'b0;
    case (MODE)
      0:       expected = ~dut_in;
      2:       expected = prev_in;
      3:       expected = CONST_W;
      default: expected = dut_in;
    endcase
    if (state == S_DRAIN)
      checked = 1'b1;
    else if (state == S_DRIVE)
      checked = (MODE != 2) || (vcnt != 8'd0);
  end

  assign mismatch = checked && (dut_out != expected);
  assign err_next = (mismatch && (err_count != 8'hFF)) ? err_count + 8'd1 : err_count;

`ifdef BB_CHECKER_STOP_ON_ERROR_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  // Sequencer: state, stimulus, error accounting and registered status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      lfsr      <= SEED_EFF;
      dut_in    <= '0;
      prev_in   <= '0;
      vcnt      <= 8'd0;
      err_count <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            lfsr      <= SEED_EFF;
            dut_in    <= SEED_EFF[WIDTH-1:0];
            vcnt      <= 8'd0;
            err_count <= 8'd0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_DRIVE: begin
          err_count <= err_next;
          prev_in   <= dut_in;
          lfsr      <= lfsr_nxt;
          if (stop_now) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
          end else if (vcnt == LAST) begin
            if (MODE == 2) begin
              state <= S_DRAIN;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (err_next == 8'd0);
            end
          end else begin
            vcnt   <= vcnt + 8'd1;
            dut_in <= lfsr_nxt[WIDTH-1:0];
          end
        end
        S_DRAIN: begin
          err_count <= err_next;
          prev_in   <= dut_in;
          state     <= S_DONE;
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (err_next == 8'd0);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bb_stimulus_checker.sv
// Bench for bb_stimulus_checker: four instances (MODE 0..3) next to small
// behavioural black boxes that can be switched between correct and faulty.
module tb_bb_stimulus_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  start_v = 4'b0;
  logic [3:0]  busy_v, done_v, pass_v;
  logic [7:0]  err_v [4];
  logic [3:0]  behav = 4'b0;

  logic        din0, dout0;
  logic [3:0]  din1, dout1;
  logic        din2, dout2, r2 = 1'b0;
  logic [7:0]  din3, dout3;

  int compared = 0;
  int mismatched = 0;

  localparam int NV [4] = '{16, 255, 16, 10};
  localparam int WV [4] = '{1, 4, 1, 8};

  always #5 clock = ~clock;

  // black boxes
  assign dout0 = behav[0] ? din0 : ~din0;
  assign dout1 = behav[1] ? ~din1 : din1;
  always @(posedge clock) r2 <= din2;
  assign dout2 = behav[2] ? din2 : r2;
  assign dout3 = behav[3] ? 8'h5B : 8'h5A;

  bb_stimulus_checker #(.MODE(0), .WIDTH(1), .NUM_VECTORS(16)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start_v[0]), .dut_in(din0), .dut_out(dout0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]));
  bb_stimulus_checker #(.MODE(1), .WIDTH(4), .NUM_VECTORS(255)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start_v[1]), .dut_in(din1), .dut_out(dout1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]));
  bb_stimulus_checker #(.MODE(2), .WIDTH(1), .NUM_VECTORS(16)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start_v[2]), .dut_in(din2), .dut_out(dout2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]));
  bb_stimulus_checker #(.MODE(3), .WIDTH(8), .VALUE('h5A), .NUM_VECTORS(10)) u3 (
    .clock(clock), .reset_n(reset_n), .start(start_v[3]), .dut_in(din3), .dut_out(dout3),
    .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]), .err_count(err_v[3]));

  logic [15:0] vec [256];

  typedef struct {
    int k;
    int cyc;
    int err;
    bit ps;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int k;
    bit b;
    bit mid;
  } run_t;
  run_t tbl [9];

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic logic [15:0] din_of(input int k);
    case (k)
      0:       return {15'b0, din0};
      1:       return {12'b0, din1};
      2:       return {15'b0, din2};
      default: return {8'b0, din3};
    endcase
  endfunction

  // Expected outcome of one run from the vector model.
  function automatic exp_t model(input int k, input bit b);
    exp_t e;
    int cnt, first_e;
    bit mm;
    cnt = 0;
    first_e = 0;
    for (int i = 0; i < NV[k]; i++) begin
      if (k == 2) mm = b && (i > 0) && (vec[i][0] != vec[i-1][0]);
      else        mm = b;
      if (mm) begin
        cnt++;
        if (first_e == 0) first_e = i + 1;
      end
    end
    e.k   = k;
    e.err = (cnt > 255) ? 255 : cnt;
    e.cyc = (k == 2) ? NV[k] + 1 : NV[k];
`ifdef BB_CHECKER_STOP_ON_ERROR_EN
    if (first_e != 0) begin
      e.cyc = first_e;
      e.err = 1;
    end
`endif
    e.ps = (e.err == 0);
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_v), 0);
    chk({tag, "_done"}, int'(done_v), 0);
    chk({tag, "_pass"}, int'(pass_v), 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_err%0d", tag, k), int'(err_v[k]), 0);
      chk($sformatf("%s_din%0d", tag, k), int'(din_of(k)), 0);
    end
  endtask

  // Start one run; abort_at > 0 stops after that many samples (no result pop).
  task automatic run(input int k, input bit b, input bit mid, input int abort_at);
    exp_t e;
    int s;
    logic [15:0] mask;
    mask = 16'((32'd1 << WV[k]) - 1);
    behav[k] = b;
    if (abort_at == 0) sbq.push_back(model(k, b));
    @(negedge clock);
    start_v[k] = 1'b1;
    @(posedge clock);
    #1;
    start_v[k] = 1'b0;
    s = 0;
    chk($sformatf("k%0d_busy_first", k), int'(busy_v[k]), 1);
    chk($sformatf("k%0d_err_cleared", k), int'(err_v[k]), 0);
    while (!done_v[k] && s < NV[k] + 6) begin
      if (abort_at != 0 && s == abort_at) return;
      if (busy_v[k] && s < NV[k])
        chk($sformatf("k%0d_din_v%0d", k, s), int'(din_of(k)), int'(vec[s] & mask));
      start_v[k] = mid && (s == 2);
      @(posedge clock);
      #1;
      s++;
      if (busy_v[k] && done_v[k]) chk($sformatf("k%0d_busy_and_done", k), 1, 0);
    end
    start_v[k] = 1'b0;
    chk($sformatf("k%0d_done_timeout", k), int'(done_v[k]), 1);
    e = sbq.pop_front();
    chk($sformatf("k%0d_run_cycles", e.k), s, e.cyc);
    chk($sformatf("k%0d_err_count", e.k), int'(err_v[e.k]), e.err);
    chk($sformatf("k%0d_pass", e.k), int'(pass_v[e.k]), int'(e.ps));
    chk($sformatf("k%0d_busy_in_done", e.k), int'(busy_v[e.k]), 0);
    repeat (2) @(posedge clock);
    #1;
    chk($sformatf("k%0d_done_held", e.k), int'(done_v[e.k]), 1);
  endtask

  initial begin
    vec[0] = 16'hACE1;
    for (int i = 0; i < 255; i++)
      vec[i+1] = {vec[i][14:0], vec[i][15] ^ vec[i][13] ^ vec[i][12] ^ vec[i][10]};

    tbl[0] = '{k: 0, b: 1'b0, mid: 1'b0};
    tbl[1] = '{k: 0, b: 1'b1, mid: 1'b0};
    tbl[2] = '{k: 0, b: 1'b0, mid: 1'b1};
    tbl[3] = '{k: 2, b: 1'b0, mid: 1'b0};
    tbl[4] = '{k: 2, b: 1'b1, mid: 1'b0};
    tbl[5] = '{k: 3, b: 1'b1, mid: 1'b0};
    tbl[6] = '{k: 3, b: 1'b0, mid: 1'b1};
    tbl[7] = '{k: 1, b: 1'b1, mid: 1'b0};
    tbl[8] = '{k: 1, b: 1'b0, mid: 1'b1};

    #12;
    check_all_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all_zero("idle");

    for (int t = 0; t < 9; t++)
      run(tbl[t].k, tbl[t].b, tbl[t].mid, 0);

    // reset during vector 5 of a run, then rerun from SEED
    run(1, 1'b0, 1'b0, 5);
    reset_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clock);
    reset_n = 1'b1;
    run(1, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
